// File: rtl/quadrant_tracker_pkg.sv
// Shared widths and FSM state type for the quadrant tracker.
package quadrant_tracker_pkg;

    // Width of the incoming dx/dy displacements (two's complement).
    localparam int IN_W  = 7;
    // Width of the x/y position accumulators (two's complement).
    localparam int POS_W = 8;

    // IDLE: ready for a command; WAIT_REL: waiting for dav_ to rise;
    // OVF: a position overflow was seen, frozen until reset.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_REL = 2'd1,
        OVF      = 2'd2
    } state_t;

endpackage

// File: rtl/quadrant_tracker_if.sv
// Producer-to-tracker bus: displacement pair, dav_/rfd handshake, results.
//
// Handshake: the producer drives dx/dy and pulls dav_ low; the tracker
// samples them on the first rising edge where it is in IDLE and dav_ is
// low, and drops rfd on that same edge. The producer must then raise dav_;
// the tracker raises rfd on the edge that samples dav_ high. dx/dy are
// don't-care while dav_ is high. Holding dav_ low never repeats a command.
interface quadrant_tracker_if;
    import quadrant_tracker_pkg::*;

    logic signed [IN_W-1:0] dx;
    logic signed [IN_W-1:0] dy;
    logic                   dav_;
    logic                   rfd;
    logic [1:0]             q;
    logic                   ow;

    // Producer side.
    modport master (
        output dx, dy, dav_,
        input  rfd, q, ow
    );

    // Tracker side.
    modport slave (
        input  dx, dy, dav_,
        output rfd, q, ow
    );

endinterface

// File: rtl/quadrant_tracker_sext_add_ovf.sv
// Sign-extending adder: POS_W accumulator plus IN_W displacement, with
// a flag for results that do not fit back into POS_W bits.
module sext_add_ovf
    import quadrant_tracker_pkg::*;
(
    input  logic signed [POS_W-1:0] acc,
    input  logic signed [IN_W-1:0]  delta,
    output logic signed [POS_W-1:0] sum,
    output logic                    ovf
);

    logic signed [POS_W:0] wide;

    // Add in POS_W+1 bits so the true result is always representable;
    // the top two bits differ exactly when it is outside -128..+127.
    always_comb begin
        wide = {acc[POS_W-1], acc} + {{(POS_W + 1 - IN_W){delta[IN_W-1]}}, delta};
        sum  = wide[POS_W-1:0];
        ovf  = wide[POS_W] ^ wide[POS_W-1];
    end

endmodule

// File: rtl/quadrant_tracker.sv
// Position tracker: accumulates (dx, dy) commands taken over a dav_/rfd
// handshake, reports the quadrant of the position and latches overflow.
module quadrant_tracker
    import quadrant_tracker_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    quadrant_tracker_if.slave    bus,
    output state_t               state
);

    state_t                  state_q, state_n;
    logic signed [POS_W-1:0] x_q, x_n;
    logic signed [POS_W-1:0] y_q, y_n;
    logic [1:0]              q_q, q_n;
    logic                    ow_q, ow_n;
    logic                    rfd_q, rfd_n;

    logic signed [POS_W-1:0] sum_x, sum_y;
    logic                    ovf_x, ovf_y;

    sext_add_ovf u_add_x (
        .acc   (x_q),
        .delta (bus.dx),
        .sum   (sum_x),
        .ovf   (ovf_x)
    );

    sext_add_ovf u_add_y (
        .acc   (y_q),
        .delta (bus.dy),
        .sum   (sum_y),
        .ovf   (ovf_y)
    );

    // Next-state and next-register values; everything holds by default.
    always_comb begin
        state_n = state_q;
        x_n     = x_q;
        y_n     = y_q;
        q_n     = q_q;
        ow_n    = ow_q;
        rfd_n   = rfd_q;
        case (state_q)
            IDLE: begin
                if (!bus.dav_) begin
                    rfd_n = 1'b0;
                    if (ovf_x || ovf_y) begin
                        // Position is left untouched so q keeps its last value.
                        ow_n    = 1'b1;
                        state_n = OVF;
                    end else begin
                        x_n     = sum_x;
                        y_n     = sum_y;
                        q_n     = {sum_x[POS_W-1], sum_y[POS_W-1]};
                        state_n = WAIT_REL;
                    end
                end
            end
            WAIT_REL: begin
                if (bus.dav_) begin
                    rfd_n   = 1'b1;
                    state_n = IDLE;
                end
            end
            OVF: begin
                rfd_n = 1'b0;
                ow_n  = 1'b1;
            end
            default: begin
                state_n = IDLE;
                rfd_n   = 1'b1;
            end
        endcase
    end

    // State and output registers; reset wins over everything.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            q_q     <= 2'b00;
            ow_q    <= 1'b0;
            rfd_q   <= 1'b1;
        end else begin
            state_q <= state_n;
            x_q     <= x_n;
            y_q     <= y_n;
            q_q     <= q_n;
            ow_q    <= ow_n;
            rfd_q   <= rfd_n;
        end
    end

    assign bus.rfd = rfd_q;
    assign bus.q   = q_q;
    assign bus.ow  = ow_q;
    assign state   = state_q;

endmodule

// File: tb/tb_quadrant_tracker.sv
// Directed plus randomized bench for quadrant_tracker against an
// integer-arithmetic reference position model.
module tb_quadrant_tracker;
    import quadrant_tracker_pkg::*;

    logic   clock;
    logic   reset;
    state_t state;

    quadrant_tracker_if bus ();

    quadrant_tracker dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus),
        .state (state)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp;
    int n_fail;

    // reference model: plain integer position and an overflow flag
    int m_x;
    int m_y;
    bit m_ovf;

    function automatic logic [1:0] m_q();
        return {m_x < 0, m_y < 0};
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input bit exp_rfd);
        check({tag, ".q"},   {6'd0, bus.q},   {6'd0, m_q()});
        check({tag, ".ow"},  {7'd0, bus.ow},  {7'd0, m_ovf});
        check({tag, ".rfd"}, {7'd0, bus.rfd}, {7'd0, exp_rfd});
    endtask

    task automatic model_cmd(input int dxv, input int dyv);
        int nx;
        int ny;
        if (m_ovf) return;
        nx = m_x + dxv;
        ny = m_y + dyv;
        if (nx < -128 || nx > 127 || ny < -128 || ny > 127) begin
            m_ovf = 1'b1;
        end else begin
            m_x = nx;
            m_y = ny;
        end
    endtask

    // one-edge reset, optionally with a pending command on the bus
    task automatic do_reset(input bit dav_low);
        @(negedge clock);
        reset    = 1'b1;
        bus.dav_ = ~dav_low;
        bus.dx   = 7'sd5;
        bus.dy   = -7'sd9;
        @(negedge clock);
        reset    = 1'b0;
        bus.dav_ = 1'b1;
        m_x   = 0;
        m_y   = 0;
        m_ovf = 1'b0;
        check_outputs("reset", 1'b1);
    endtask

    // full handshake with fixed-latency checks on each edge
    task automatic do_cmd(input string tag, input int dxv, input int dyv);
        @(negedge clock);
        bus.dx   = 7'(dxv);
        bus.dy   = 7'(dyv);
        bus.dav_ = 1'b0;
        model_cmd(dxv, dyv);
        @(negedge clock);
        check_outputs({tag, ".acc"}, 1'b0);
        bus.dav_ = 1'b1;
        bus.dx   = 7'($urandom);
        bus.dy   = 7'($urandom);
        @(negedge clock);
        check_outputs({tag, ".rel"}, !m_ovf);
    endtask

    initial begin
        n_cmp    = 0;
        n_fail   = 0;
        reset    = 1'b1;
        bus.dav_ = 1'b1;
        bus.dx   = '0;
        bus.dy   = '0;
        m_x = 0; m_y = 0; m_ovf = 1'b0;
        repeat (2) @(negedge clock);

        // reset state, then the quadrant walk and negative overflow, twice
        for (int pass = 0; pass < 2; pass++) begin
            do_reset(1'b0);
            do_cmd("walk1", -32, 0);
            check("walk1.q10", {6'd0, bus.q}, 8'h02);
            do_cmd("walk2", 0, -32);
            check("walk2.q11", {6'd0, bus.q}, 8'h03);
            do_cmd("walk3", 63, 0);
            check("walk3.q01", {6'd0, bus.q}, 8'h01);
            do_cmd("walk4", 0, 63);
            check("walk4.q00", {6'd0, bus.q}, 8'h00);
            do_cmd("neg1", -64, 0);
            do_cmd("neg2", -64, 0);
            check("neg2.ow0", {7'd0, bus.ow}, 8'h00);
            do_cmd("neg3", -64, 0);
            check("neg3.ow1", {7'd0, bus.ow}, 8'h01);
            check("neg3.q10", {6'd0, bus.q}, 8'h02);
            // commands in OVF must change nothing
            for (int i = 0; i < 4; i++) do_cmd("ovf_toggle", 10, 10);
        end

        // reset takes priority over a command presented on the same edge
        do_reset(1'b1);

        // holding dav_ low accumulates exactly once
        @(negedge clock);
        bus.dx = 7'sd1; bus.dy = 7'sd1; bus.dav_ = 1'b0;
        model_cmd(1, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check_outputs("hold", 1'b0);
        end
        bus.dav_ = 1'b1;
        @(negedge clock);
        check_outputs("hold.rel", 1'b1);
        // (1,1) -> (-1,-1) only if the hold added once
        do_cmd("hold.probe", -2, -2);
        check("hold.q11", {6'd0, bus.q}, 8'h03);

        // positive limit: 126, 127, then overflow
        do_reset(1'b0);
        do_cmd("pos63a", 63, 63);
        do_cmd("pos63b", 63, 63);
        do_cmd("pos127", 1, 1);
        check("pos127.ow0", {7'd0, bus.ow}, 8'h00);
        do_cmd("pos128", 1, 0);
        check("pos128.ow1", {7'd0, bus.ow}, 8'h01);

        // negative limit: -128 fits, -129 does not (y only)
        do_reset(1'b0);
        do_cmd("neg64a", 0, -64);
        do_cmd("neg64b", 0, -64);
        check("neg128.ow0", {7'd0, bus.ow}, 8'h00);
        do_cmd("neg129", 0, -1);
        check("neg129.ow1", {7'd0, bus.ow}, 8'h01);

        // randomized runs until overflow or a command budget, with idle gaps
        for (int round = 0; round < 6; round++) begin
            do_reset(1'b0);
            for (int k = 0; k < 40 && !m_ovf; k++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clock);
                    check_outputs("rnd.idle", 1'b1);
                end
                do_cmd("rnd", int'($urandom_range(0, 127)) - 64,
                              int'($urandom_range(0, 127)) - 64);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/quadrant_tracker.md
# quadrant_tracker

Accumulates signed 7-bit displacement pairs (dx, dy) into an 8-bit signed position (x, y). It reports the quadrant of that position on `q`. A position overflow latches `ow` and halts the block until reset. Data is taken from a producer over a `dav_`/`rfd` handshake, and the block sits directly behind the producer as a position-tracking peripheral.

## Interface
- `IN_W`, 7: width of `dx`/`dy`, two's complement.
- `POS_W`, 8: width of the internal x/y accumulators, two's complement (range -128..+127).

- `clock`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `dx`  in  IN_W  signed x displacement; valid while `dav_`=0.
- `dy`  in  IN_W  signed y displacement; valid while `dav_`=0.
- `dav_`  in  1  data available, active low; driven by the producer.
- `rfd`  out  1  ready for data, active high.
- `q`  out  2  quadrant: `q[1]` = (x<0), `q[0]` = (y<0).
- `ow`  out  1  overflow flag; sticky until reset.

## Operation
- Registers: `x`, `y` (POS_W signed), `q`, `ow`, `rfd`, and the state.
- States:
  - `IDLE` (`rfd`=1): waits for a command.
  - `WAIT_REL` (`rfd`=0): waits for the producer to release `dav_`.
  - `OVF` (`rfd`=0, `ow`=1): terminal until reset.
- `IDLE` with `dav_`=0 sampled:
  - Sign-extend `dx`/`dy` to POS_W+1 bits.
  - Compute `nx` = x+dx and `ny` = y+dy in POS_W+1 bits.
  - Overflow occurs if either sum lies outside -128..+127.
  - On overflow: go to `OVF`, set `ow`=1 and `rfd`=0. `x`, `y` and `q` keep their previous values.
  - Otherwise: set x←nx and y←ny, `q`←{nx<0, ny<0}, `rfd`=0, then go to `WAIT_REL`.
- `IDLE` with `dav_`=1: hold all state.
- `WAIT_REL` with `dav_`=1 sampled: set `rfd`=1 and go to `IDLE`. Inputs are ignored in this state.
- `OVF`: ignores `dav_`, `dx` and `dy`. `rfd` stays 0 and `ow` stays 1.
- Zero counts as non-negative, so position (0,0) gives `q`=00.
- `dx`/`dy` contents are don't-care whenever `dav_`=1.

## Timing
- `reset`=1 at a rising edge forces:
  - `x`=`y`=0, `q`=00, `ow`=0, `rfd`=1, state `IDLE`.
  - This applies in any state, including `OVF` and mid-handshake.
  - `reset` has priority over every other input.
- Command latency:
  - `dav_` low sampled at edge N → `rfd`=0 and the updated `q` (or `ow`=1) are visible after edge N.
  - `q` and `rfd` change on the same edge.
- Release latency: `dav_` high sampled at edge M (M>N) → `rfd`=1 after edge M, and a new command is accepted from edge M+1.
- One command is accepted per handshake. Holding `dav_` low does not re-accumulate.
- All outputs are registered, with no combinational input→output paths.

## Structure
- Package `quadrant_tracker_pkg`: holds `IN_W`/`POS_W` defaults and the state enum (`IDLE`, `WAIT_REL`, `OVF`).
- Sub-module `sext_add_ovf`:
  - Sign-extends a signed IN_W operand and adds it to a signed POS_W operand.
  - Returns the POS_W sum and an overflow bit.
  - It is instantiated twice, once for x and once for y.
- Top level: state machine, registers, output drive.

## Test plan
- Reset → `ow`=0, `q`=00, `rfd`=1.
- Command sequence, each with a full handshake (`dav_`=0 until `rfd`=0, then `dav_`=1 until `rfd`=1):

  | dx | dy | required `q` |
  |---|---|---|
  | 0x60 (-32) | 0 | 10 |
  | 0 | 0x60 (-32) | 11 |
  | 0x3F (+63) | 0 | 01 |
  | 0 | 0x3F (+63) | 00 |

  The expected positions after each command are (-32,0), (-32,-32), (31,-32) and (31,31).
- From (31,31), apply (0x40 = -64, 0) → `q`=10 with x=-33. Apply (-64, 0) → x=-97, `q` stays 10, `ow`=0. Apply (-64, 0) again → `ow`=1 one edge after `dav_` is sampled low. `rfd` falls and never returns to 1, and `q` stays 10.
- While in `OVF`, toggle `dav_` several times → no change on any output.
- Assert `reset` for one edge while in `OVF` → `ow`=0, `q`=00, `rfd`=1. Repeating the full sequence gives identical results.
- Positive-limit checks:
  - Hold `dav_` low for 5 cycles with (+1, +1) → only one accumulation, `rfd` stays 0 until `dav_` rises.
  - From (0,0), apply +63 twice → 126, no overflow.
  - Then apply +1 → 127, no overflow.
  - Then apply +1 → `ow`=1.
